// File: rtl/imem_pkg.sv
// Shared state encoding and constants for the instruction-memory loader.
package imem_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2
   } state_e;

   localparam logic [7:0] NOP_INSTR = 8'h00;

endpackage

// File: rtl/imem_loader_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, and a
// single-clk pulse on each accepted rising level.
module btn_debounce #(
   parameter int unsigned      DEB_W      = 20,
   parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic pulse
);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [DEB_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;

   // The counter only runs while the synced input disagrees with the accepted
   // level, so any return to the old level restarts the stability window.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == DEB_CYCLES - DEB_W'(1)) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + DEB_W'(1);
      end
      pulse_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction RAM with operator load path (switches + write button) and a
// registered fetch port for the core in RUN mode.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned      ADDR_W     = 8,
   parameter logic [19:0]      DEB_CYCLES = 20'd500000,
   parameter int unsigned      DEB_W      = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        sw_data,
   input  logic              btn_write,
   input  logic              btn_run,
   input  logic [ADDR_W-1:0] pc,
   output logic [7:0]        instruction,
   output logic              run,
   output logic [ADDR_W:0]   load_count,
   output logic              full,
   output logic [7:0]        last_byte
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic wr_pulse, run_pulse;

   btn_debounce #(.DEB_W(DEB_W), .DEB_CYCLES(DEB_W'(DEB_CYCLES))) u_deb_write (
      .clk(clk), .reset(reset), .btn_raw(btn_write), .pulse(wr_pulse)
   );

   btn_debounce #(.DEB_W(DEB_W), .DEB_CYCLES(DEB_W'(DEB_CYCLES))) u_deb_run (
      .clk(clk), .reset(reset), .btn_raw(btn_run), .pulse(run_pulse)
   );

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [ADDR_W:0]   load_count_q, load_count_d;
   logic [7:0]        instr_q, instr_d;
   logic              run_q, run_d;
   logic [7:0]        last_byte_q, last_byte_d;

   logic [7:0]        mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              full_w;

   assign full_w = (load_count_q == (ADDR_W+1)'(DEPTH));

   always_comb begin
      state_d      = state_q;
      clr_ptr_d    = clr_ptr_q;
      load_count_d = load_count_q;
      last_byte_d  = last_byte_q;
      instr_d      = NOP_INSTR;
      mem_we       = 1'b0;
      mem_addr     = clr_ptr_q;
      mem_wdata    = NOP_INSTR;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = LOAD;
         end
         LOAD: begin
            // run wins over a coincident write
            if (run_pulse) begin
               state_d = RUN;
            end else if (wr_pulse && !full_w) begin
               mem_we       = 1'b1;
               mem_addr     = load_count_q[ADDR_W-1:0];
               mem_wdata    = sw_data;
               last_byte_d  = sw_data;
               load_count_d = load_count_q + (ADDR_W+1)'(1);
            end
         end
         RUN: begin
            if (run_pulse) begin
               state_d      = LOAD;
               load_count_d = '0;
            end else begin
               instr_d = mem[pc];
            end
         end
         default: state_d = CLEAR;
      endcase
      run_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= CLEAR;
         clr_ptr_q    <= '0;
         load_count_q <= '0;
         instr_q      <= NOP_INSTR;
         run_q        <= 1'b0;
         last_byte_q  <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         clr_ptr_q    <= clr_ptr_d;
         load_count_q <= load_count_d;
         instr_q      <= instr_d;
         run_q        <= run_d;
         last_byte_q  <= last_byte_d;
      end
   end

   // RAM has no reset; the CLEAR pass zeroes it after every reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   assign instruction = instr_q;
   assign run         = run_q;
   assign load_count  = load_count_q;
   assign full        = full_w;
   assign last_byte   = last_byte_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with a small RAM and short debounce window.
module tb_imem_loader;
   import imem_pkg::*;

   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [7:0]       sw_data;
   logic             btn_write, btn_run;
   logic [ADDR_W-1:0] pc;
   logic [7:0]       instruction;
   logic             run;
   logic [ADDR_W:0]  load_count;
   logic             full;
   logic [7:0]       last_byte;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] model_mem [DEPTH];
   int         model_cnt;
   logic [7:0] model_last;
   logic [7:0] exp_q [$];

   imem_loader #(.ADDR_W(ADDR_W), .DEB_CYCLES(20'd4), .DEB_W(20)) dut (
      .clk(clk), .reset(reset), .sw_data(sw_data), .btn_write(btn_write),
      .btn_run(btn_run), .pc(pc), .instruction(instruction), .run(run),
      .load_count(load_count), .full(full), .last_byte(last_byte)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_clear(input string tag);
      int cnt = 0;
      while (dut.state_q != LOAD && cnt < 50) begin
         tick();
         cnt++;
      end
      chk(tag, cnt, DEPTH);
   endtask

   task automatic press(input logic w, input logic r, input int hold);
      btn_write = w;
      btn_run   = r;
      repeat (hold) tick();
      btn_write = 1'b0;
      btn_run   = 1'b0;
      repeat (12) tick();
   endtask

   // model write: LOAD mode only, ignored when full
   task automatic do_write(input logic [7:0] d);
      sw_data = d;
      press(1'b1, 1'b0, 12);
      if (model_cnt < DEPTH) begin
         model_mem[model_cnt] = d;
         model_cnt++;
         model_last = d;
      end
   endtask

   task automatic fetch(input int a);
      pc = ADDR_W'(a);
      exp_q.push_back(model_mem[a]);
      tick();
      chk($sformatf("fetch_pc%0d", a), instruction, exp_q.pop_front());
   endtask

   initial begin
      reset = 1'b0; sw_data = '0; btn_write = 1'b0; btn_run = 1'b0; pc = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
      model_cnt = 0; model_last = 8'h00;
      #1;
      chk("rst_run", run, 0);
      chk("rst_instr", instruction, 8'h00);
      chk("rst_cnt", load_count, 0);
      chk("rst_full", full, 0);
      chk("rst_last", last_byte, 8'h00);
      repeat (3) tick();
      reset = 1'b1;
      wait_clear("clear_cycles");
      chk("load_run", run, 0);
      chk("load_instr", instruction, 8'h00);
      chk("load_cnt", load_count, 0);

      // basic load then fetch
      do_write(8'h12); do_write(8'h4D); do_write(8'hC1);
      chk("cnt3", load_count, ADDR_W'(model_cnt));
      chk("last_c1", last_byte, model_last);
      chk("instr_in_load", instruction, 8'h00);
      press(1'b0, 1'b1, 12);
      chk("to_run", run, 1);
      fetch(1); fetch(5); fetch(0); fetch(2);
      // write presses in RUN are ignored
      sw_data = 8'h77;
      press(1'b1, 1'b0, 12);
      chk("run_wr_cnt", load_count, 3);
      chk("run_wr_last", last_byte, 8'hC1);
      fetch(3);

      // back to LOAD: count resets, glitch vs held press
      press(1'b0, 1'b1, 12);
      chk("back_load", run, 0);
      chk("reload_cnt", load_count, 0);
      chk("reload_instr", instruction, 8'h00);
      model_cnt = 0;
      sw_data = 8'hA5;
      press(1'b1, 1'b0, 2);
      chk("glitch_cnt", load_count, 0);
      do_write(8'hA5);
      sw_data = 8'h5A;
      press(1'b1, 1'b0, 100);
      if (model_cnt < DEPTH) begin
         model_mem[model_cnt] = 8'h5A; model_cnt++; model_last = 8'h5A;
      end
      chk("held_cnt", load_count, 2);
      press(1'b0, 1'b1, 12);
      fetch(0); fetch(1); fetch(2);

      // fill to full, 9th press ignored
      press(1'b0, 1'b1, 12);
      model_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         do_write(i == 8 ? 8'hFF : 8'h30 + 8'(i));
         chk($sformatf("fill_cnt%0d", i), load_count, model_cnt);
         chk($sformatf("fill_full%0d", i), full, model_cnt == DEPTH);
      end
      chk("full_last", last_byte, model_last);
      press(1'b0, 1'b1, 12);
      for (int a = 0; a < DEPTH; a++) fetch(a);

      // simultaneous write + run in LOAD: run wins, no write
      press(1'b0, 1'b1, 12);
      model_cnt = 0;
      sw_data = 8'hEE;
      press(1'b1, 1'b1, 12);
      chk("simul_run", run, 1);
      chk("simul_cnt", load_count, 0);
      chk("simul_last", last_byte, model_last);
      fetch(0);

      // async reset mid-RUN clears outputs before the next edge
      pc = 3'd1;
      tick();
      chk("pre_rst_instr", instruction, model_mem[1]);
      #3 reset = 1'b0;
      #1;
      chk("async_instr", instruction, 8'h00);
      chk("async_run", run, 0);
      chk("async_cnt", load_count, 0);
      chk("async_last", last_byte, 8'h00);
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
      model_cnt = 0;
      tick();
      reset = 1'b1;
      wait_clear("clear_cycles2");
      press(1'b0, 1'b1, 12);
      chk("rerun", run, 1);
      fetch(0); fetch(1); fetch(7);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Instruction-side responder for the 8-bit CPU core. In LOAD mode, the operator keys instruction bytes into an internal instruction RAM using switches and a debounced write button. In RUN mode, the block answers the core's fetch address (pc) with the stored byte on instruction. Before the first load after reset, the block clears the RAM so that unwritten locations always read as 8'h00.

Parameters:
- ADDR_W, 8, fetch/write address width; RAM depth DEPTH = 2**ADDR_W.
- DEB_CYCLES, 20'd500000, number of consecutive stable clk samples required before a button level is accepted.
- DEB_W, 20, width of the debounce counter; must hold DEB_CYCLES.

Ports:
- clk  in  1  system clock (undivided board clock).
- reset  in  1  asynchronous, active-low reset.
- sw_data  in  8  instruction byte from the switches.
- btn_write  in  1  raw, asynchronous write pushbutton.
- btn_run  in  1  raw, asynchronous LOAD/RUN toggle pushbutton.
- pc  in  ADDR_W  fetch address from the core.
- instruction  out  8  fetched instruction byte.
- run  out  1  1 = RUN mode; also drives the core's active-high reset as ~run at top level.
- load_count  out  ADDR_W+1  number of bytes written since the last entry to LOAD.
- full  out  1  asserted when load_count == DEPTH.
- last_byte  out  8  most recently written byte, for the 7-seg echo.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=CLEAR, clr_ptr=0, load_count=0, instruction=8'h00, run=0, last_byte=8'h00, full=0.
  - Debouncer state is cleared.
  - RAM contents are not reset asynchronously; they are cleared by the CLEAR state.
- FSM states: CLEAR, LOAD, RUN.
- CLEAR:
  - Writes 8'h00 to RAM[clr_ptr] and increments clr_ptr once per clk.
  - After writing address DEPTH-1, moves to LOAD. Takes exactly DEPTH cycles.
  - Button pulses in CLEAR are ignored. instruction=8'h00.
- LOAD:
  - On a write pulse while !full: RAM[load_count[ADDR_W-1:0]] <= sw_data, last_byte <= sw_data, load_count <= load_count+1. full follows combinationally from load_count==DEPTH.
  - A write pulse while full is ignored; there is no wrap-around.
  - A run pulse moves to RUN. instruction stays 8'h00 throughout LOAD.
- RUN:
  - Every clk, instruction <= RAM[pc]. This is a registered read with 1-clk latency, which the divided core clock absorbs.
  - Write pulses are ignored.
  - A run pulse moves to LOAD and sets load_count=0. RAM contents are kept, so reloading overwrites from address 0 and leaves the tail intact.
  - On that transition, instruction <= 8'h00 on the same edge.
- Simultaneous write and run pulses in the same cycle: run takes precedence and the write is discarded.
- run is a registered output, equal to (state==RUN).
- Debounce, per button:
  - A 2-flop synchronizer feeds a counter that resets whenever the synced level differs from the accepted level.
  - When the counter reaches DEB_CYCLES-1, the accepted level updates.
  - A 0->1 change of the accepted level produces a one-clk pulse.
  - A held button produces exactly one pulse.
  - Glitches shorter than DEB_CYCLES produce no pulse.
- Reset asserted mid-LOAD or mid-RUN: returns to CLEAR, and the RAM is re-zeroed.
- Width rules:
  - load_count is ADDR_W+1 bits so it can represent DEPTH.
  - The RAM address is load_count[ADDR_W-1:0].
  - pc is used unmodified. The core's 8-bit pc with ADDR_W<8 uses only the low ADDR_W bits, so fetches wrap modulo DEPTH.

Decomposition:
- Package imem_pkg:
  - State encoding localparams: CLEAR=2'd0, LOAD=2'd1, RUN=2'd2.
  - NOP_INSTR=8'h00.
- Sub-module btn_debounce (params DEB_CYCLES, DEB_W; ports clk, reset, btn_raw, pulse), instantiated twice.
- RAM is inferred inline as a synchronous-write, registered-read array.

Test Plan (ADDR_W=3, DEB_CYCLES=4):
- Release reset and hold idle -> exactly 8 cycles in CLEAR, then LOAD; run=0, instruction=8'h00, load_count=0.
- In LOAD, write 8'h12, 8'h4D, 8'hC1 with stable presses -> load_count=3, last_byte=8'hC1. Then press run, pc=1 -> instruction=8'h4D one clk after pc is applied; pc=5 -> 8'h00.
- Apply a 2-cycle btn_write glitch and a 100-cycle held press -> 0 and 1 writes respectively; load_count increments by 1 only.
- Perform 9 write presses -> full=1 after the 8th write, load_count=8; the 9th press leaves RAM[0] unchanged.
- Align write and run pulses to the same cycle in LOAD -> state=RUN, load_count unchanged, no RAM write.
- In RUN, pull reset low asynchronously mid-cycle -> instruction=8'h00 and run=0 immediately. After release, the CLEAR pass completes; a subsequent RUN with pc=0 -> instruction=8'h00.
